reservation_station: RTL and testbench

Five-entry Tomasulo reservation station with an integrated register map table, sitting between decode/dispatch and the functional units. Each dispatched instruction is placed in a fixed slot chosen by its functional-unit class. The block tags it with its ROB number and resolves each source operand to either a producer tag or a ready value. Entries are released by per-entry completion strobes.

---
 rtl/reservation_station_pkg.sv | 38 +++
 rtl/reservation_station_map_table.sv | 53 +++++
 rtl/reservation_station.sv | 137 +++++++++++++
 tb/tb_reservation_station.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: class codes, register aliases,
// widths and the entry record.
package reservation_station_pkg;

   localparam int XLEN     = 32;
   localparam int NUM_RS   = 5;
   localparam int TAG_W    = 32;
   localparam int NUM_REGS = 32;
   localparam int REG_W    = 5;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_ALU  = 3'd1,
      CLS_LD   = 3'd2,
      CLS_ST   = 3'd3,
      CLS_FP   = 3'd4
   } rs_class_e;

   localparam logic [REG_W-1:0] REG_F0 = 5'd1;
   localparam logic [REG_W-1:0] REG_F1 = 5'd2;
   localparam logic [REG_W-1:0] REG_F2 = 5'd3;
   localparam logic [REG_W-1:0] REG_R1 = 5'd4;

   typedef struct packed {
      logic             busy;
      logic [2:0]       opcode;
      logic [TAG_W-1:0] t;
      logic [TAG_W-1:0] t1;
      logic [TAG_W-1:0] t2;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
   } rs_entry_t;

   function automatic logic class_valid(input logic [2:0] op);
      return (op >= 3'd1) && (op <= 3'd4);
   endfunction

endpackage

// File: rtl/reservation_station_map_table.sv
// Register map table: per architectural register, the ROB tag of its pending
// producer. Two combinational reads, one write, and a tag-match clear per entry.
module map_table
   import reservation_station_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_W-1:0]  rd_addr_1,
   input  logic [REG_W-1:0]  rd_addr_2,
   output logic [TAG_W-1:0]  rd_tag_1,
   output logic [TAG_W-1:0]  rd_tag_2,
   input  logic              wr_en,
   input  logic [REG_W-1:0]  wr_addr,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [NUM_RS-1:0] clr_valid,
   input  logic [TAG_W-1:0]  clr_tag [NUM_RS]
);

   logic [TAG_W-1:0] map_q [NUM_REGS];
   logic [TAG_W-1:0] map_d [NUM_REGS];

   assign rd_tag_1 = (rd_addr_1 == '0) ? '0 : map_q[rd_addr_1];
   assign rd_tag_2 = (rd_addr_2 == '0) ? '0 : map_q[rd_addr_2];

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         map_d[r] = map_q[r];
         for (int k = 0; k < NUM_RS; k++) begin
            if (clr_valid[k] && (map_q[r] == clr_tag[k])) begin
               map_d[r] = '0;
            end
         end
      end
      // A dispatch write lands after the clears so it wins on a shared register.
      if (wr_en && (wr_addr != '0)) begin
         map_d[wr_addr] = wr_tag;
      end
      map_d[0] = '0;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            map_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            map_q[r] <= map_d[r];
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Five-entry reservation station: fixed class-to-slot allocation, operand
// resolution against the map table, and release by per-entry completion strobes.
module reservation_station
   import reservation_station_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              rs_valid,
   input  logic [2:0]        opcode,
   input  logic [TAG_W-1:0]  ROB_number,
   input  logic [REG_W-1:0]  input_reg_1,
   input  logic [REG_W-1:0]  input_reg_2,
   input  logic [REG_W-1:0]  dest_reg,
   input  logic [XLEN-1:0]   value_1,
   input  logic [XLEN-1:0]   value_2,
   input  logic [NUM_RS-1:0] done_signal,
   output logic [NUM_RS-1:0] busy_signal,
   output logic [6:0]        out_opcode [NUM_RS],
   output logic [TAG_W-1:0]  T          [NUM_RS],
   output logic [TAG_W-1:0]  T1         [NUM_RS],
   output logic [TAG_W-1:0]  T2         [NUM_RS],
   output logic [XLEN-1:0]   V1         [NUM_RS],
   output logic [XLEN-1:0]   V2         [NUM_RS]
);

   rs_entry_t entries_q [NUM_RS];
   rs_entry_t entries_d [NUM_RS];

   logic [TAG_W-1:0]  src_tag_1;
   logic [TAG_W-1:0]  src_tag_2;
   logic              alloc_en;
   logic [2:0]        alloc_slot;
   logic [NUM_RS-1:0] clr_valid;
   logic [TAG_W-1:0]  clr_tag [NUM_RS];
   logic [NUM_RS-1:0] busy_pre;

   map_table u_map_table (
      .clock     (clock),
      .reset     (reset),
      .rd_addr_1 (input_reg_1),
      .rd_addr_2 (input_reg_2),
      .rd_tag_1  (src_tag_1),
      .rd_tag_2  (src_tag_2),
      .wr_en     (alloc_en),
      .wr_addr   (dest_reg),
      .wr_tag    (ROB_number),
      .clr_valid (clr_valid),
      .clr_tag   (clr_tag)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RS; gi++) begin : g_busy
         assign busy_pre[gi] = entries_q[gi].busy;
      end
   endgenerate

   // Slot choice looks only at pre-edge busy bits, so a slot freed this cycle stays empty.
   always_comb begin
      alloc_en   = 1'b0;
      alloc_slot = 3'd0;
      if (rs_valid && class_valid(opcode)) begin
         case (opcode)
            CLS_ALU: begin
               alloc_slot = 3'd0;
               alloc_en   = !busy_pre[0];
            end
            CLS_LD: begin
               alloc_slot = 3'd1;
               alloc_en   = !busy_pre[1];
            end
            CLS_ST: begin
               alloc_slot = 3'd2;
               alloc_en   = !busy_pre[2];
            end
            CLS_FP: begin
               if (!busy_pre[3]) begin
                  alloc_slot = 3'd3;
                  alloc_en   = 1'b1;
               end else begin
                  alloc_slot = 3'd4;
                  alloc_en   = !busy_pre[4];
               end
            end
            default: begin
               alloc_en   = 1'b0;
               alloc_slot = 3'd0;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_RS; i++) begin
         entries_d[i] = entries_q[i];
         clr_valid[i] = done_signal[i] && entries_q[i].busy;
         clr_tag[i]   = entries_q[i].t;
         if (clr_valid[i]) begin
            entries_d[i] = '0;
         end
      end
      if (alloc_en) begin
         entries_d[alloc_slot].busy   = 1'b1;
         entries_d[alloc_slot].opcode = opcode;
         entries_d[alloc_slot].t      = ROB_number;
         entries_d[alloc_slot].t1     = src_tag_1;
         entries_d[alloc_slot].v1     = (src_tag_1 != '0) ? '0 : value_1;
         entries_d[alloc_slot].t2     = src_tag_2;
         entries_d[alloc_slot].v2     = (src_tag_2 != '0) ? '0 : value_2;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_RS; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_RS; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_RS; gi++) begin : g_out
         assign busy_signal[gi] = entries_q[gi].busy;
         assign out_opcode[gi]  = {4'b0000, entries_q[gi].opcode};
         assign T[gi]           = entries_q[gi].t;
         assign T1[gi]          = entries_q[gi].t1;
         assign T2[gi]          = entries_q[gi].t2;
         assign V1[gi]          = entries_q[gi].v1;
         assign V2[gi]          = entries_q[gi].v2;
      end
   endgenerate

endmodule

// File: tb/tb_reservation_station.sv
// Directed-vector bench for reservation_station with hand-computed expectations.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic              clock;
   logic              reset;
   logic              rs_valid;
   logic [2:0]        opcode;
   logic [TAG_W-1:0]  ROB_number;
   logic [REG_W-1:0]  input_reg_1;
   logic [REG_W-1:0]  input_reg_2;
   logic [REG_W-1:0]  dest_reg;
   logic [XLEN-1:0]   value_1;
   logic [XLEN-1:0]   value_2;
   logic [NUM_RS-1:0] done_signal;
   logic [NUM_RS-1:0] busy_signal;
   logic [6:0]        out_opcode [NUM_RS];
   logic [TAG_W-1:0]  T          [NUM_RS];
   logic [TAG_W-1:0]  T1         [NUM_RS];
   logic [TAG_W-1:0]  T2         [NUM_RS];
   logic [XLEN-1:0]   V1         [NUM_RS];
   logic [XLEN-1:0]   V2         [NUM_RS];

   int n_vec;
   int n_miss;

   reservation_station dut (
      .clock       (clock),
      .reset       (reset),
      .rs_valid    (rs_valid),
      .opcode      (opcode),
      .ROB_number  (ROB_number),
      .input_reg_1 (input_reg_1),
      .input_reg_2 (input_reg_2),
      .dest_reg    (dest_reg),
      .value_1     (value_1),
      .value_2     (value_2),
      .done_signal (done_signal),
      .busy_signal (busy_signal),
      .out_opcode  (out_opcode),
      .T           (T),
      .T1          (T1),
      .T2          (T2),
      .V1          (V1),
      .V2          (V2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic check_entry(input int i, input logic [6:0] op, input logic [31:0] t,
                              input logic [31:0] t1, input logic [31:0] v1,
                              input logic [31:0] t2, input logic [31:0] v2);
      check_vec($sformatf("e%0d.opcode", i), {25'd0, out_opcode[i]}, {25'd0, op});
      check_vec($sformatf("e%0d.T", i),  T[i],  t);
      check_vec($sformatf("e%0d.T1", i), T1[i], t1);
      check_vec($sformatf("e%0d.V1", i), V1[i], v1);
      check_vec($sformatf("e%0d.T2", i), T2[i], t2);
      check_vec($sformatf("e%0d.V2", i), V2[i], v2);
   endtask

   task automatic check_busy(input string tag, input logic [4:0] exp);
      check_vec(tag, {27'd0, busy_signal}, {27'd0, exp});
   endtask

   task automatic set_inputs(input logic [2:0] op, input logic [31:0] rob,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] dn);
      rs_valid    = 1'b1;
      opcode      = op;
      ROB_number  = rob;
      input_reg_1 = s1;
      input_reg_2 = s2;
      dest_reg    = d;
      value_1     = a;
      value_2     = b;
      done_signal = dn;
   endtask

   task automatic dispatch(input logic [2:0] op, input logic [31:0] rob,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] dn);
      set_inputs(op, rob, s1, s2, d, a, b, dn);
      @(posedge clock);
      #1;
      rs_valid    = 1'b0;
      done_signal = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check_busy({tag, ".busy"}, 5'b00000);
      for (int i = 0; i < NUM_RS; i++) begin
         check_entry(i, 7'd0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      n_vec       = 0;
      n_miss      = 0;
      reset       = 1'b0;
      rs_valid    = 1'b0;
      opcode      = '0;
      ROB_number  = '0;
      input_reg_1 = '0;
      input_reg_2 = '0;
      dest_reg    = '0;
      value_1     = '0;
      value_2     = '0;
      done_signal = '0;

      @(posedge clock);
      #1;
      reset = 1'b1;
      check_all_zero("reset");

      // LD ROB1 src r1/0 dest f1
      dispatch(CLS_LD, 1, REG_R1, 5'd0, REG_F1, 4, 6, 5'b00000);
      check_busy("ld.busy", 5'b00010);
      check_entry(1, 7'd2, 1, 0, 4, 0, 6);

      // FP ROB2 src f0/f1 dest f2: f1 depends on ROB1
      dispatch(CLS_FP, 2, REG_F0, REG_F1, REG_F2, 8, 10, 5'b00000);
      check_busy("fp.busy", 5'b01010);
      check_entry(3, 7'd4, 2, 0, 8, 1, 0);

      // ST ROB3 src f2/0 dest r1 while entry 1 completes
      dispatch(CLS_ST, 3, REG_F2, 5'd0, REG_R1, 12, 14, 5'b00010);
      check_busy("st.busy", 5'b01100);
      check_entry(2, 7'd3, 3, 2, 0, 0, 14);
      check_entry(1, 7'd0, 0, 0, 0, 0, 0);

      // FP ROB4 goes to entry 4; f1 was cleared, r1 maps to 3
      dispatch(CLS_FP, 4, REG_F1, REG_R1, REG_F0, 20, 22, 5'b00000);
      check_busy("fp2.busy", 5'b11100);
      check_entry(4, 7'd4, 4, 0, 20, 3, 0);

      // Third FP is dropped and must not touch the map (dest f1)
      dispatch(CLS_FP, 5, 5'd0, 5'd0, REG_F1, 1, 1, 5'b00000);
      check_busy("fp3.busy", 5'b11100);
      check_vec("fp3.e3.T", T[3], 2);
      check_vec("fp3.e4.T", T[4], 4);

      // ALU ROB6 src f1/f0: f1 still ready, f0 maps to 4
      dispatch(CLS_ALU, 6, REG_F1, REG_F0, 5'd0, 30, 32, 5'b00000);
      check_busy("alu.busy", 5'b11101);
      check_entry(0, 7'd1, 6, 0, 30, 4, 0);

      // ALU ROB7 while entry 0 completes: slot not reused this cycle
      dispatch(CLS_ALU, 7, 5'd0, 5'd0, 5'd0, 1, 1, 5'b00001);
      check_busy("alu_reuse.busy", 5'b11100);
      check_entry(0, 7'd0, 0, 0, 0, 0, 0);

      // ALU ROB8 src=dest=f0 while ROB4 completes: old tag seen, dest write wins
      dispatch(CLS_ALU, 8, REG_F0, 5'd0, REG_F0, 40, 42, 5'b10000);
      check_busy("alu8.busy", 5'b01101);
      check_entry(0, 7'd1, 8, 4, 0, 0, 42);
      check_entry(4, 7'd0, 0, 0, 0, 0, 0);

      // LD ROB9 src f0/f2: f0 now maps to 8, f2 to 2
      dispatch(CLS_LD, 9, REG_F0, REG_F2, 5'd0, 1, 2, 5'b00000);
      check_busy("ld9.busy", 5'b01111);
      check_entry(1, 7'd2, 9, 8, 0, 2, 0);

      // Reset dominates a simultaneous dispatch and completion
      set_inputs(CLS_LD, 10, REG_F2, 5'd0, REG_F2, 3, 3, 5'b11111);
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset       = 1'b1;
      rs_valid    = 1'b0;
      done_signal = '0;
      check_all_zero("midreset");

      // Invalid class code is ignored
      dispatch(3'd5, 12, 5'd0, 5'd0, REG_F2, 1, 1, 5'b00000);
      check_busy("badop.busy", 5'b00000);

      // f2 was cleared by reset (and not written by the bad op)
      dispatch(CLS_ST, 11, REG_F2, REG_F2, 5'd0, 50, 52, 5'b00000);
      check_busy("st11.busy", 5'b00100);
      check_entry(2, 7'd3, 11, 0, 50, 0, 52);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
